// File: rtl/uart_rx.sv
// UART receiver: oversampled, 3-sample majority vote, optional parity.
// Ports: clk, rst (sync, active-high), RX_IN (async serial line), PAR_EN,
// PAR_TYP (0 even / 1 odd), PRESCALE (clk per bit), P_DATA (last good byte),
// DATA_VALID / PAR_ERR / STP_ERR (one-cycle pulses after the stop decision).
module uart_rx #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  RX_IN,
  input  logic                  PAR_EN,
  input  logic                  PAR_TYP,
  input  logic [5:0]            PRESCALE,
  output logic [DATA_WIDTH-1:0] P_DATA,
  output logic                  DATA_VALID,
  output logic                  PAR_ERR,
  output logic                  STP_ERR
);

  localparam int CW = $clog2(DATA_WIDTH + 3);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic [SYNC_STAGES-1:0] r_sync;
  logic                  w_rx_s;
  logic [5:0]            r_edge_cnt;
  logic [5:0]            r_prescale;
  logic [CW-1:0]         r_bit_cnt;
  logic                  r_par_en;
  logic                  r_par_typ;
  logic                  r_s0;
  logic                  r_s1;
  logic                  r_mism;
  logic [DATA_WIDTH-1:0] r_shift;
  logic [5:0]            w_half;
  logic                  w_smp0;
  logic                  w_smp1;
  logic                  w_dec;
  logic                  w_wrap;
  logic                  w_bit;
  logic                  w_last;
  logic                  w_start;

  assign w_rx_s  = r_sync[SYNC_STAGES-1];
  assign w_half  = {1'b0, r_prescale[5:1]};
  assign w_smp0  = (r_edge_cnt == w_half - 6'd1);
  assign w_smp1  = (r_edge_cnt == w_half);
  assign w_dec   = (r_edge_cnt == w_half + 6'd1);
  assign w_wrap  = (r_edge_cnt == r_prescale - 6'd1);
  assign w_last  = (r_bit_cnt == CW'(DATA_WIDTH));
  assign w_start = (r_state == S_IDLE) && !w_rx_s;

  // Third sample is the live line in the decision cycle.
  assign w_bit = (r_s0 & r_s1) | (r_s0 & w_rx_s) | (r_s1 & w_rx_s);

  always_ff @(posedge clk) begin
    if (rst) r_sync <= '1;
    else     r_sync <= {r_sync[SYNC_STAGES-2:0], RX_IN};
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:
        if (!w_rx_s) w_next = S_START;
      S_START:
        if (w_dec && w_bit) w_next = S_IDLE;
        else if (w_wrap)    w_next = S_DATA;
      S_DATA:
        if (w_wrap && w_last)
          w_next = r_par_en ? S_PARITY : S_STOP;
      S_PARITY:
        if (w_wrap) w_next = S_STOP;
      S_STOP:
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (w_dec) w_next = S_IDLE;
      default:
        w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (r_state == S_IDLE || w_next == S_IDLE) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= '0;
    end else if (w_wrap) begin
      r_edge_cnt <= '0;
      r_bit_cnt  <= r_bit_cnt + 1'b1;
    end else begin
      r_edge_cnt <= r_edge_cnt + 6'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_prescale <= '0;
      r_par_en   <= 1'b0;
      r_par_typ  <= 1'b0;
      r_s0       <= 1'b1;
      r_s1       <= 1'b1;
      r_mism     <= 1'b0;
      r_shift    <= '0;
    end else begin
      if (w_start) begin
        r_prescale <= PRESCALE;
        r_par_en   <= PAR_EN;
        r_par_typ  <= PAR_TYP;
        r_mism     <= 1'b0;
      end
      if (w_smp0) r_s0 <= w_rx_s;
      if (w_smp1) r_s1 <= w_rx_s;
      if (r_state == S_DATA && w_dec)
        r_shift <= {w_bit, r_shift[DATA_WIDTH-1:1]};
      // Mismatch = received bit differs from expected parity.
      if (r_state == S_PARITY && w_dec)
        r_mism <= w_bit ^ (^r_shift) ^ r_par_typ;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      PAR_ERR    <= 1'b0;
      STP_ERR    <= 1'b0;
      if (r_state == S_STOP && w_dec) begin
        if (w_bit) begin
          if (r_mism) begin
            PAR_ERR <= 1'b1;
          end else begin
            P_DATA     <= r_shift;
            DATA_VALID <= 1'b1;
          end
        end else begin
          STP_ERR <= 1'b1;
          PAR_ERR <= r_mism;
        end
      end
    end
  end

endmodule
